reg_wb_queue: RTL and testbench
===============================

// Module: reg_wb_queue
// PURPOSE
// - Write-back initiator for the 8x8 register bank's single write port; drives addrw/din/write.
// - Buffers ALU/load results in a small FIFO and issues one register write per cycle.
// - Stalls while the bank write port is claimed by another master.
// - Reports per-register pending-write status so decode can detect RAW hazards.
// PARAMETERS
// - DEPTH  4  FIFO entries; power of 2, range 2..16
// - AW     3  register address width (8 registers)
// - DW     8  data width
// PORTS
// - clk         in   1      rising-edge clock
// - rst         in   1      synchronous, active-high reset
// - res_valid   in   1      result offered by producer
// - res_ready   out  1      queue can accept; equals !full
// - res_addr    in   AW     destination register
// - res_data    in   DW     result value
// - port_busy   in   1      another master owns the bank write port this cycle
// - addrw       out  AW     bank write address (head entry)
// - din         out  DW     bank write data (head entry)
// - write       out  1      bank write enable
// - query_addr  in   AW     register probed by decode
// - pending     out  1      a queued entry targets query_addr
// - count       out  log2(DEPTH)+1  entries currently held
// BEHAVIOUR
// - Push: res_valid && res_ready at a rising edge stores {res_addr,res_data} at the tail.
// - res_ready depends only on full; it never depends on a same-cycle pop.
// - Issue (combinational from state): write = !empty && !port_busy; addrw/din = head entry.
// - Pop: the head is removed at the same edge that the bank samples write=1.
// - Latency: a push at edge N into an empty queue gives write=1 during cycle N..N+1; the bank is updated at edge N+1.
// - port_busy=1: write=0; head, pointers and count hold; no entry is lost.
// - Ordering: strict FIFO; multiple writes to the same register land in push order, so the last value wins.
// - Simultaneous push and pop: count unchanged; both pointers advance.
// - A push when empty with port_busy=0 is not bypassed to write; it is issued in the next cycle.
// - Pointers: wrap modulo DEPTH; full when count==DEPTH, empty when count==0.
// - pending: combinational OR over valid entries of (entry.addr==query_addr).
//   - It includes the head being written this cycle.
//   - It drops in the cycle after the last matching pop.
// - Reset: rst at an edge empties the queue (count=0, pointers=0). Afterwards:
//   - write=0, addrw=0, din=0 (the empty queue forces both to 0)
//   - pending=0, res_ready=1
//   - An in-flight push at a reset edge is discarded.
// - Register-bank write timing is unaffected: the bank still writes at posedge when write=1.
// CONFIGURATION
// - WB_BYPASS_EN defined: adds outputs fwd_hit (1) and fwd_data (DW).
//   - fwd_hit = pending.
//   - fwd_data = data of the NEWEST valid entry whose addr==query_addr; 0 when there is no hit.
//   - Decode can forward the value instead of stalling.
// - WB_BYPASS_EN undefined: fwd_hit/fwd_data ports and the priority-select logic are absent.
//   - pending is still present; behaviour is otherwise identical.
// TESTING
// - Reset: assert rst 1 cycle mid-stream with 3 entries queued -> next cycle count=0, write=0, pending=0, res_ready=1.
// - Single write: push {addr=5,data=8'h7F}, port_busy=0 -> next cycle write=1, addrw=5, din=8'h7F; then count=0.
// - Fill/stall: port_busy=1, push 4 entries (R1=11,R2=22,R3=33,R4=44) -> res_ready=0, count=4.
//   - A 5th push is refused.
//   - Drop port_busy -> writes R1..R4 in order on 4 consecutive cycles.
// - Full with simultaneous pop: count=4, port_busy=0, res_valid=1 -> no push accepted that cycle.
//   - Next cycle count=3, res_ready=1.
// - Hazard: port_busy=1, push R6=8'h10 then R6=8'h20; query_addr=6 -> pending=1.
//   - With WB_BYPASS_EN: fwd_data=8'h20.
//   - Release port_busy -> pending=0 after the second R6 write; bank R6 ends at 8'h20.
// - Wrap-around: 10 push/pop pairs of R0..R7 data 0..9 with port_busy toggling every 3 cycles.
//   - Scoreboard check: write sequence equals push sequence; no loss or duplication across the pointer wrap.

Source files
------------

// File: rtl/reg_wb_queue_if.sv
// reg_wb_queue_if -- result-offer channel between an ALU/load producer and
// the register write-back queue.
//   res_valid  producer -> queue   a result is offered this cycle
//   res_ready  queue -> producer   queue can accept (not full)
//   res_addr   producer -> queue   destination register
//   res_data   producer -> queue   result value
// Modports: master = producer side, slave = queue side.
interface reg_wb_queue_if #(
  parameter int AW = 3,
  parameter int DW = 8
);
  logic          res_valid;
  logic          res_ready;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_data;

  modport master (output res_valid, output res_addr, output res_data, input res_ready);
  modport slave  (input res_valid, input res_addr, input res_data, output res_ready);
endinterface

// File: rtl/reg_wb_queue.sv
// reg_wb_queue -- write-back initiator for the register bank's single write
// port. Results are buffered in a DEPTH-entry FIFO and the head entry is
// written to the bank whenever no other master owns the port.
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   res           result channel (reg_wb_queue_if.slave)
//   port_busy     another master owns the bank write port this cycle
//   addrw/din     bank write address/data (head entry, 0 when empty)
//   write         bank write enable; the head pops on the same edge
//   query_addr    register probed by decode
//   pending       some queued entry targets query_addr
//   count         entries currently held
//   fwd_hit/fwd_data  newest queued value for query_addr
//                 (only when WB_BYPASS_EN is defined)
// Configuration macro: WB_BYPASS_EN enables the forwarding outputs.
module reg_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  reg_wb_queue_if.slave          res,
  input  logic                   port_busy,
  output logic [AW-1:0]          addrw,
  output logic [DW-1:0]          din,
  output logic                   write,
  input  logic [AW-1:0]          query_addr,
  output logic                   pending,
`ifdef WB_BYPASS_EN
  output logic                   fwd_hit,
  output logic [DW-1:0]          fwd_data,
`endif
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;
  logic pending_s;
  logic [PW-1:0] idx_s;
`ifdef WB_BYPASS_EN
  logic [DW-1:0] fwd_data_s;
`endif

  assign full_s  = (count_q == CNT_FULL);
  assign empty_s = (count_q == {CW{1'b0}});
  // Ready is a function of occupancy only, so a full queue refuses a push
  // even on a cycle where the head is popping.
  assign push_s  = res.res_valid && !full_s;
  assign pop_s   = !empty_s && !port_busy;

  assign res.res_ready = !full_s;
  assign count         = count_q;
  assign pending       = pending_s;
`ifdef WB_BYPASS_EN
  assign fwd_hit  = pending_s;
  assign fwd_data = fwd_data_s;
`endif

  // Bank issue: head entry drives the port; empty queue forces address/data to zero.
  always_comb begin
    write = pop_s;
    if (empty_s) begin
      addrw = {AW{1'b0}};
      din   = {DW{1'b0}};
    end else begin
      addrw = addr_q[head_q];
      din   = data_q[head_q];
    end
  end

  // Next-state: tail write on push, head advance on pop, occupancy update.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_s) begin
      addr_d[tail_q] = res.res_addr;
      data_d[tail_q] = res.res_data;
      tail_d         = tail_q + PTR_ONE;
    end else begin
      tail_d = tail_q;
    end
    if (pop_s) begin
      head_d = head_q + PTR_ONE;
    end else begin
      head_d = head_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Hazard lookup: walk entries oldest to newest so the last match is the
  // newest value for the probed register.
  always_comb begin
    pending_s = 1'b0;
    idx_s     = head_q;
`ifdef WB_BYPASS_EN
    fwd_data_s = {DW{1'b0}};
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx_s     = head_q + PW'(k);
      pending_s = pending_s | ((CW'(k) < count_q) && (addr_q[idx_s] == query_addr));
`ifdef WB_BYPASS_EN
      fwd_data_s = ((CW'(k) < count_q) && (addr_q[idx_s] == query_addr)) ?
                   data_q[idx_s] : fwd_data_s;
`endif
    end
  end

  // State registers with synchronous reset; a push at a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= {AW{1'b0}};
        data_q[i] <= {DW{1'b0}};
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_queue.sv
// Bench for reg_wb_queue: directed vector table plus hand sequences for the
// RAW hazard and pointer wrap-around.
module tb_reg_wb_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       port_busy;
  logic [2:0] addrw;
  logic [7:0] din;
  logic       write;
  logic [2:0] query_addr;
  logic       pending;
  logic [2:0] count;
`ifdef WB_BYPASS_EN
  logic       fwd_hit;
  logic [7:0] fwd_data;
`endif

  reg_wb_queue_if #(.AW(3), .DW(8)) rif ();

  reg_wb_queue #(.DEPTH(4), .AW(3), .DW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .res        (rif.slave),
    .port_busy  (port_busy),
    .addrw      (addrw),
    .din        (din),
    .write      (write),
    .query_addr (query_addr),
    .pending    (pending),
`ifdef WB_BYPASS_EN
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
`endif
    .count      (count)
  );

  always #5 clk = ~clk;

  // Register bank model: captures writes at the rising edge.
  logic [7:0] bank [8];
  always @(posedge clk) begin
    if (write) bank[addrw] <= din;
  end

  typedef struct {
    logic       rst;
    logic       v;
    logic [2:0] a;
    logic [7:0] d;
    logic       busy;
    logic [2:0] q;
    logic       rdy;
    logic       wr;
    logic [2:0] aw;
    logic [7:0] dn;
    logic       pend;
    logic [2:0] cnt;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic r, logic v, logic [2:0] a, logic [7:0] d,
                              logic b, logic [2:0] q, logic rdy, logic wr,
                              logic [2:0] aw, logic [7:0] dn, logic p, logic [2:0] c);
    vec_t t;
    t.rst = r; t.v = v; t.a = a; t.d = d; t.busy = b; t.q = q;
    t.rdy = rdy; t.wr = wr; t.aw = aw; t.dn = dn; t.pend = p; t.cnt = c;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic r, logic v, logic [2:0] a, logic [7:0] d, logic b, logic [2:0] q);
    rst = r; rif.res_valid = v; rif.res_addr = a; rif.res_data = d;
    port_busy = b; query_addr = q;
  endtask

  logic [10:0] exp_q[$];
  logic [10:0] e;
  int np;
  int nw;

  initial begin
    drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
    repeat (2) @(negedge clk);

    //          rst  v   a     d      busy q     rdy  wr   aw    dn     pend cnt
    // reset state, single write
    vq.push_back(mk(1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,1'b1,1'b0,3'd0,8'h00,1'b0,3'd0));
    vq.push_back(mk(1'b0,1'b1,3'd5,8'h7F,1'b0,3'd5,1'b1,1'b0,3'd0,8'h00,1'b0,3'd0));
    vq.push_back(mk(1'b0,1'b0,3'd0,8'h00,1'b0,3'd5,1'b1,1'b1,3'd5,8'h7F,1'b1,3'd1));
    vq.push_back(mk(1'b0,1'b0,3'd0,8'h00,1'b0,3'd5,1'b1,1'b0,3'd0,8'h00,1'b0,3'd0));
    // fill while stalled, 5th push refused, drain in order
    vq.push_back(mk(1'b0,1'b1,3'd1,8'h11,1'b1,3'd1,1'b1,1'b0,3'd0,8'h00,1'b0,3'd0));
    vq.push_back(mk(1'b0,1'b1,3'd2,8'h22,1'b1,3'd1,1'b1,1'b0,3'd1,8'h11,1'b1,3'd1));
    vq.push_back(mk(1'b0,1'b1,3'd3,8'h33,1'b1,3'd3,1'b1,1'b0,3'd1,8'h11,1'b0,3'd2));
    vq.push_back(mk(1'b0,1'b1,3'd4,8'h44,1'b1,3'd3,1'b1,1'b0,3'd1,8'h11,1'b1,3'd3));
    vq.push_back(mk(1'b0,1'b1,3'd5,8'h55,1'b1,3'd4,1'b0,1'b0,3'd1,8'h11,1'b1,3'd4));
    vq.push_back(mk(1'b0,1'b0,3'd0,8'h00,1'b0,3'd5,1'b0,1'b1,3'd1,8'h11,1'b0,3'd4));
    vq.push_back(mk(1'b0,1'b0,3'd0,8'h00,1'b0,3'd1,1'b1,1'b1,3'd2,8'h22,1'b0,3'd3));
    vq.push_back(mk(1'b0,1'b0,3'd0,8'h00,1'b0,3'd4,1'b1,1'b1,3'd3,8'h33,1'b1,3'd2));
    vq.push_back(mk(1'b0,1'b0,3'd0,8'h00,1'b0,3'd4,1'b1,1'b1,3'd4,8'h44,1'b1,3'd1));
    vq.push_back(mk(1'b0,1'b0,3'd0,8'h00,1'b0,3'd4,1'b1,1'b0,3'd0,8'h00,1'b0,3'd0));
    // full with simultaneous pop: push refused; then push+pop holds count
    vq.push_back(mk(1'b0,1'b1,3'd0,8'hA0,1'b1,3'd0,1'b1,1'b0,3'd0,8'h00,1'b0,3'd0));
    vq.push_back(mk(1'b0,1'b1,3'd1,8'hA1,1'b1,3'd0,1'b1,1'b0,3'd0,8'hA0,1'b1,3'd1));
    vq.push_back(mk(1'b0,1'b1,3'd2,8'hA2,1'b1,3'd7,1'b1,1'b0,3'd0,8'hA0,1'b0,3'd2));
    vq.push_back(mk(1'b0,1'b1,3'd3,8'hA3,1'b1,3'd3,1'b1,1'b0,3'd0,8'hA0,1'b0,3'd3));
    vq.push_back(mk(1'b0,1'b1,3'd7,8'hA7,1'b0,3'd3,1'b0,1'b1,3'd0,8'hA0,1'b1,3'd4));
    vq.push_back(mk(1'b0,1'b0,3'd0,8'h00,1'b1,3'd7,1'b1,1'b0,3'd1,8'hA1,1'b0,3'd3));
    vq.push_back(mk(1'b0,1'b1,3'd7,8'hB7,1'b0,3'd7,1'b1,1'b1,3'd1,8'hA1,1'b0,3'd3));
    vq.push_back(mk(1'b0,1'b0,3'd0,8'h00,1'b0,3'd7,1'b1,1'b1,3'd2,8'hA2,1'b1,3'd3));
    vq.push_back(mk(1'b0,1'b0,3'd0,8'h00,1'b0,3'd7,1'b1,1'b1,3'd3,8'hA3,1'b1,3'd2));
    vq.push_back(mk(1'b0,1'b0,3'd0,8'h00,1'b0,3'd7,1'b1,1'b1,3'd7,8'hB7,1'b1,3'd1));
    vq.push_back(mk(1'b0,1'b0,3'd0,8'h00,1'b0,3'd7,1'b1,1'b0,3'd0,8'h00,1'b0,3'd0));
    // reset mid-stream with 3 queued; push at the reset edge is discarded
    vq.push_back(mk(1'b0,1'b1,3'd1,8'hC1,1'b1,3'd2,1'b1,1'b0,3'd0,8'h00,1'b0,3'd0));
    vq.push_back(mk(1'b0,1'b1,3'd2,8'hC2,1'b1,3'd2,1'b1,1'b0,3'd1,8'hC1,1'b0,3'd1));
    vq.push_back(mk(1'b0,1'b1,3'd3,8'hC3,1'b1,3'd2,1'b1,1'b0,3'd1,8'hC1,1'b1,3'd2));
    vq.push_back(mk(1'b1,1'b1,3'd4,8'hC4,1'b1,3'd2,1'b1,1'b0,3'd1,8'hC1,1'b1,3'd3));
    vq.push_back(mk(1'b0,1'b0,3'd0,8'h00,1'b0,3'd4,1'b1,1'b0,3'd0,8'h00,1'b0,3'd0));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].rst, vq[i].v, vq[i].a, vq[i].d, vq[i].busy, vq[i].q);
      #1;
      chk($sformatf("v%0d.res_ready", i), 32'(rif.res_ready), 32'(vq[i].rdy));
      chk($sformatf("v%0d.write", i),     32'(write),         32'(vq[i].wr));
      chk($sformatf("v%0d.addrw", i),     32'(addrw),         32'(vq[i].aw));
      chk($sformatf("v%0d.din", i),       32'(din),           32'(vq[i].dn));
      chk($sformatf("v%0d.pending", i),   32'(pending),       32'(vq[i].pend));
      chk($sformatf("v%0d.count", i),     32'(count),         32'(vq[i].cnt));
    end

    // Hazard: two queued writes to R6, newest value 8'h20 wins.
    @(negedge clk); drive(1'b0, 1'b1, 3'd6, 8'h10, 1'b1, 3'd6); #1;
    chk("haz0.pending", 32'(pending), 32'd0);
    @(negedge clk); drive(1'b0, 1'b1, 3'd6, 8'h20, 1'b1, 3'd6); #1;
    chk("haz1.pending", 32'(pending), 32'd1);
    @(negedge clk); drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6); #1;
    chk("haz2.pending", 32'(pending), 32'd1);
    chk("haz2.count", 32'(count), 32'd2);
`ifdef WB_BYPASS_EN
    chk("haz2.fwd_hit", 32'(fwd_hit), 32'd1);
    chk("haz2.fwd_data", 32'(fwd_data), 32'h20);
`endif
    @(negedge clk); drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd6); #1;
    chk("haz3.write", 32'(write), 32'd1);
    chk("haz3.din", 32'(din), 32'h10);
    chk("haz3.pending", 32'(pending), 32'd1);
    @(negedge clk); #1;
    chk("haz4.din", 32'(din), 32'h20);
    chk("haz4.pending", 32'(pending), 32'd1);
    @(negedge clk); #1;
    chk("haz5.pending", 32'(pending), 32'd0);
    chk("haz5.write", 32'(write), 32'd0);
    chk("haz5.bank_r6", 32'(bank[6]), 32'h20);

    // Wrap-around: 10 results through the 4-entry ring with port_busy toggling.
    np = 0;
    nw = 0;
    for (int cyc = 0; cyc < 200 && nw < 10; cyc++) begin
      @(negedge clk);
      port_busy = ((cyc / 3) % 2) == 1;
      rif.res_valid = (np < 10);
      rif.res_addr  = 3'(np % 8);
      rif.res_data  = 8'(np);
      #1;
      if (write) begin
        if (exp_q.size() == 0) begin
          chk("wrap.spurious_write", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("wrap%0d.addrw", nw), 32'(addrw), 32'(e[10:8]));
          chk($sformatf("wrap%0d.din", nw),   32'(din),   32'(e[7:0]));
        end
        nw++;
      end
      if (rif.res_valid && rif.res_ready) begin
        exp_q.push_back({rif.res_addr, rif.res_data});
        np++;
      end
    end
    chk("wrap.writes", 32'(nw), 32'd10);
    @(negedge clk); rif.res_valid = 1'b0; port_busy = 1'b0; #1;
    chk("wrap.count_end", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
